// File: rtl/multipli_booth_r4.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multipli_booth_r4
// Sequential radix-4 (modified) Booth multiplier. It retires one recoded digit
// per clock, so a product takes N = (tamano+2)/2 iterations. Operands are
// treated as two's complement or as unsigned, selected per operation.
//
// Ports
//   CLOCK        system clock, all state updates on the rising edge
//   RESET        asynchronous, active-low reset
//   START        operation request, accepted only while idle
//   SIGNED_MODE  1 = two's-complement operands, 0 = unsigned (sampled with START)
//   A            multiplicand (sampled with START)
//   B            multiplier   (sampled with START)
//   S            product, holds the last result until the next END_MULT
//   END_MULT     one-cycle pulse, S is valid in that same cycle
//   BUSY         high from START acceptance through the END_MULT cycle
//
// Timing: START sampled at edge k -> END_MULT high after edge k+N+1.
// A new START is honoured only once the END_MULT cycle is over (BUSY low).
// -----------------------------------------------------------------------------
module multipli_booth_r4 #(
    parameter int tamano = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  SIGNED_MODE,
    input  logic [tamano-1:0]     A,
    input  logic [tamano-1:0]     B,
    output logic [2*tamano-1:0]   S,
    output logic                  END_MULT,
    output logic                  BUSY
);

    // Two guard bits make unsigned operands look positive to the signed
    // recoder and keep W even, so W/2 Booth digits cover the whole operand.
    localparam int W  = tamano + 2;
    localparam int N  = W / 2;
    // The running sum never exceeds 3*|M|, so two bits above W are enough.
    localparam int AW = W + 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    if ((tamano % 2) != 0 || tamano < 4) begin : g_bad_param
        $error("multipli_booth_r4: tamano must be even and >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Extend an operand to W bits: sign-extend in signed mode, else zero-extend.
    function automatic logic [W-1:0] extend_op(input logic [tamano-1:0] op,
                                               input logic sgn);
        extend_op = {{2{sgn & op[tamano-1]}}, op};
    endfunction

    // Booth digit for triplet {q[1], q[0], q[-1]} applied to multiplicand m.
    function automatic logic [AW-1:0] booth_addend(input logic [2:0]   trip,
                                                   input logic [W-1:0] m);
        logic [AW-1:0] m1;
        logic [AW-1:0] m2;
        m1 = {{2{m[W-1]}}, m};
        m2 = {m1[AW-2:0], 1'b0};
        case (trip)
            3'b001, 3'b010: booth_addend = m1;
            3'b011:         booth_addend = m2;
            3'b100:         booth_addend = -m2;
            3'b101, 3'b110: booth_addend = -m1;
            3'b000, 3'b111: booth_addend = {AW{1'b0}};
            default:        booth_addend = {AW{1'b0}};
        endcase
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [W-1:0]        m_r;
    logic [AW-1:0]       acc_r;
    logic [W-1:0]        q_r;
    logic                qm1_r;
    logic [2*tamano-1:0] s_r;
    logic                end_r;
    logic                busy_r;

    logic [AW-1:0]       sum_s;
    logic                accept_s;
    logic                step_s;
    logic                capture_s;
    logic                busy_nxt_s;
    logic                end_nxt_s;

    // State register plus the registered handshake outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            end_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            end_r   <= end_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Next-state logic: CALC stays until the counter reaches N, i.e. N steps
    // done; the following edge captures the product and enters DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/control decode; BUSY and END_MULT are registered from the next state.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && START;
        step_s     = (state_r == ST_CALC) && (cnt_r != CNT_LAST);
        capture_s  = (state_r == ST_CALC) && (cnt_r == CNT_LAST);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        end_nxt_s  = (state_nxt_s == ST_DONE);
    end

    // Add the current Booth digit times M to the upper half of {acc, q}.
    always_comb begin
        sum_s = acc_r + booth_addend({q_r[1:0], qm1_r}, m_r);
    end

    // Datapath: operand latch, per-step add-and-shift by two, iteration count.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            m_r   <= {W{1'b0}};
            acc_r <= {AW{1'b0}};
            q_r   <= {W{1'b0}};
            qm1_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            m_r   <= extend_op(A, SIGNED_MODE);
            acc_r <= {AW{1'b0}};
            q_r   <= extend_op(B, SIGNED_MODE);
            qm1_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (step_s) begin
            acc_r <= {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
            q_r   <= {sum_s[1:0], q_r[W-1:2]};
            qm1_r <= q_r[1];
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

    // Result register: the product {acc, q} is exact in 2W bits, and its low
    // 2*tamano bits are the answer in both modes.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            s_r <= {(2*tamano){1'b0}};
        end else if (capture_s) begin
            s_r <= {acc_r[tamano-3:0], q_r};
        end
    end

    assign S        = s_r;
    assign END_MULT = end_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_multipli_booth_r4.sv
`timescale 1ns/1ps
// Self-checking bench for multipli_booth_r4: directed corner table, timing,
// protocol and reset sequences on a tamano=8 instance, plus randomized
// operations on tamano=4/8/16 instances compared with plain integer products.
module tb_multipli_booth_r4;

    localparam int T   = 8;
    localparam int NIT = (T + 2) / 2;
    localparam int OPS = 1200;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] prod;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rst_rand_n = 1'b0;
    logic         start;
    logic         signed_mode;
    logic [T-1:0] a;
    logic [T-1:0] b;
    logic [2*T-1:0] s;
    logic         end_mult;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multipli_booth_r4 #(.tamano(T)) u_dut (
        .CLOCK(clk), .RESET(rst_n), .START(start), .SIGNED_MODE(signed_mode),
        .A(a), .B(b), .S(s), .END_MULT(end_mult), .BUSY(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One operation on the main instance; returns product and edges to END_MULT.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic sm,
                          output logic [15:0] res, output int lt);
        a = xa; b = xb; signed_mode = sm; start = 1'b1;
        lt = -1; res = 16'h0000;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (end_mult) begin
                lt = j; res = s;
                break;
            end
        end
        @(negedge clk);
    endtask

    // Randomized instances, each with its own reference product.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int TW = (gi == 0) ? 4 : ((gi == 1) ? 8 : 16);
        localparam int TN = (TW + 2) / 2;
        logic r_start, r_sm, r_end, r_busy;
        logic [TW-1:0] r_a, r_b;
        logic [2*TW-1:0] r_s;
        logic done = 1'b0;

        multipli_booth_r4 #(.tamano(TW)) u_rand (
            .CLOCK(clk), .RESET(rst_rand_n), .START(r_start), .SIGNED_MODE(r_sm),
            .A(r_a), .B(r_b), .S(r_s), .END_MULT(r_end), .BUSY(r_busy)
        );

        function automatic logic [2*TW-1:0] ref_prod(input logic [TW-1:0] x,
                                                    input logic [TW-1:0] y,
                                                    input logic sgn);
            longint px, py, p;
            if (sgn) begin
                px = longint'($signed(x)); py = longint'($signed(y));
            end else begin
                px = longint'(x); py = longint'(y);
            end
            p = px * py;
            return p[2*TW-1:0];
        endfunction

        function automatic logic [TW-1:0] pick();
            logic [TW-1:0] v;
            v = TW'($urandom);
            case ($urandom_range(0, 5))
                0: v = '0;
                1: v = '1;
                2: v = {1'b1, {(TW-1){1'b0}}};
                3: v = {1'b0, {(TW-1){1'b1}}};
                default: v = v;
            endcase
            return v;
        endfunction

        initial begin : drive
            logic [TW-1:0]   x, y;
            logic            sgn;
            logic [2*TW-1:0] expv;
            int              lat;
            r_start = 1'b0; r_sm = 1'b0; r_a = '0; r_b = '0;
            wait (rst_rand_n === 1'b1);
            @(negedge clk);
            for (int op = 0; op < 2 * OPS; op++) begin
                sgn = (op >= OPS);
                x = pick(); y = pick();
                expv = ref_prod(x, y, sgn);
                r_a = x; r_b = y; r_sm = sgn; r_start = 1'b1;
                lat = -1;
                for (int j = 0; j < 4 * TN; j++) begin
                    @(negedge clk);
                    // Operand changes after acceptance must not matter.
                    r_start = 1'b0; r_a = pick(); r_b = pick(); r_sm = ~r_sm;
                    if (r_end) begin
                        lat = j;
                        break;
                    end
                end
                check($sformatf("rand_w%0d op%0d %0h*%0h sgn=%0b S", TW, op, x, y, sgn),
                      32'(r_s), 32'(expv));
                check($sformatf("rand_w%0d op%0d latency", TW, op), lat, TN + 1);
                @(negedge clk);
            end
            done = 1'b1;
        end
    end

    initial begin : main
        vec_t        vecs[11];
        logic [15:0] got;
        int          lat;
        int          ends;
        int          busy_cnt;

        vecs[0]  = '{a: 8'h80, b: 8'h80, sm: 1'b1, prod: 16'h4000};
        vecs[1]  = '{a: 8'h80, b: 8'h7F, sm: 1'b1, prod: 16'hC080};
        vecs[2]  = '{a: 8'hFF, b: 8'h01, sm: 1'b1, prod: 16'hFFFF};
        vecs[3]  = '{a: 8'hFF, b: 8'hFF, sm: 1'b0, prod: 16'hFE01};
        vecs[4]  = '{a: 8'h80, b: 8'h02, sm: 1'b0, prod: 16'h0100};
        vecs[5]  = '{a: 8'h00, b: 8'hC8, sm: 1'b0, prod: 16'h0000};
        vecs[6]  = '{a: 8'h03, b: 8'h05, sm: 1'b0, prod: 16'h000F};
        vecs[7]  = '{a: 8'hFF, b: 8'hFF, sm: 1'b1, prod: 16'h0001};
        vecs[8]  = '{a: 8'h7F, b: 8'h7F, sm: 1'b1, prod: 16'h3F01};
        vecs[9]  = '{a: 8'hFB, b: 8'h03, sm: 1'b1, prod: 16'hFFF1};
        vecs[10] = '{a: 8'h80, b: 8'h80, sm: 1'b0, prod: 16'h4000};

        start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        rst_n = 1'b0; rst_rand_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset S", 32'(s), 32'h0);
        check("reset END_MULT", 32'(end_mult), 32'h0);
        check("reset BUSY", 32'(busy), 32'h0);
        rst_n = 1'b1; rst_rand_n = 1'b1;
        @(negedge clk);

        // Corner-value table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sm, got, lat);
            check($sformatf("vec%0d S", i), 32'(got), 32'(vecs[i].prod));
            check($sformatf("vec%0d latency", i), lat, NIT + 1);
        end

        // Cycle-exact timing of 3*5; S keeps the previous 0x4000 until END_MULT.
        a = 8'd3; b = 8'd5; signed_mode = 1'b0; start = 1'b1;
        for (int j = 0; j <= NIT + 3; j++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("timing BUSY edge k+%0d", j), 32'(busy), 32'(j <= NIT + 1));
            check($sformatf("timing END_MULT edge k+%0d", j), 32'(end_mult), 32'(j == NIT + 1));
            check($sformatf("timing S edge k+%0d", j), 32'(s),
                  (j < NIT + 1) ? 32'h4000 : 32'h000F);
        end

        // START held high, operands scrambled while busy: one product of 7*9,
        // then the held START is taken only after returning to idle (4*5).
        a = 8'd7; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
        ends = 0;
        for (int j = 0; j < 2 * NIT + 6; j++) begin
            @(negedge clk);
            if (end_mult) ends++;
            if (j == NIT + 1) check("proto first END_MULT", 32'(end_mult), 32'h1);
            if (j == NIT + 1) check("proto first S", 32'(s), 32'd63);
            if (j == NIT + 2) check("proto BUSY low in idle", 32'(busy), 32'h0);
            if (j == NIT + 3) check("proto BUSY after re-accept", 32'(busy), 32'h1);
            if (j == 2 * NIT + 3) check("proto S held", 32'(s), 32'd63);
            if (j == 2 * NIT + 4) check("proto second S", 32'(s), 32'd20);
            if (j == 2 * NIT + 4) check("proto second END_MULT", 32'(end_mult), 32'h1);
            if (j < NIT + 2) begin
                a = 8'($urandom); b = 8'($urandom); signed_mode = ~signed_mode;
            end else if (j == NIT + 2) begin
                a = 8'd4; b = 8'd5; signed_mode = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        check("proto END_MULT pulse count", ends, 2);

        // Reset in the middle of CALC abandons the operation.
        a = 8'd100; b = 8'd3; signed_mode = 1'b0; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midreset S", 32'(s), 32'h0);
        check("midreset BUSY", 32'(busy), 32'h0);
        check("midreset END_MULT", 32'(end_mult), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ends = 0; busy_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (end_mult) ends++;
            if (busy) busy_cnt++;
        end
        check("post-reset END_MULT pulses", ends, 0);
        check("post-reset BUSY cycles", busy_cnt, 0);
        check("post-reset S", 32'(s), 32'h0);

        run_op(8'd12, 8'd12, 1'b0, got, lat);
        check("after reset 12*12", 32'(got), 32'd144);
        run_op(8'hF4, 8'd12, 1'b1, got, lat);
        check("after reset -12*12", 32'(got), 32'hFF70);

        for (int t = 0; t < 80000; t++) begin
            if (g_rand[0].done && g_rand[1].done && g_rand[2].done) break;
            @(negedge clk);
        end
        check("random runs complete", 32'({g_rand[2].done, g_rand[1].done, g_rand[0].done}), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
